bcd_calendar: RTL and testbench
===============================

# bcd_calendar

Sequential BCD time-of-day and calendar counter that keeps the running date/time between DS1302 burst reads. It advances one second per `tick` pulse and ripples carries field by field through a small state machine. It presents `year`/`month`/`date` to the combinational date-info stage and consumes that stage's `days_in_month` result to decide the date rollover. It accepts a full-time load from the DS1302 read path.

## Interface
- `RST_YEAR`, 8'h00, BCD year after reset
- `RST_MONTH`, 8'h01, BCD month after reset
- `RST_DATE`, 8'h01, BCD date after reset
- `clk` input 1 system clock, all state on rising edge
- `rst_n` input 1 reset; the clock is single and the reset is asynchronous, active-low
- `tick` input 1 one-cycle pulse, advance one second
- `load` input 1 one-cycle strobe, load all `ld_*` fields
- `ld_year`, `ld_month`, `ld_date`, `ld_hour`, `ld_min`, `ld_sec` input 8 each, BCD load values, 24-hour
- `days_in_month` input 8 BCD, from date-info stage, combinational in current `year`/`month`
- `year`, `month`, `date`, `hour`, `min`, `sec` output 8 each, registered BCD
- `busy` output 1 carry ripple in progress (state != IDLE)
- `updated` output 1 one-cycle pulse when a tick or load has fully taken effect
- `overrun` output 1 sticky, tick lost; cleared only by `load` or reset

## Operation
- States: IDLE, SEC, MIN, HOUR, DATE, MONTH, YEAR, and CLAMP (CLAMP exists only with the macro).
- IDLE: `tick` or pending tick → SEC, clear pending.
- SEC: if `sec`≠59, increment and go to IDLE. Otherwise set `sec`=00 and go to MIN.
- MIN: same rule with limit 59, then go to HOUR.
- HOUR: limit 23, then go to DATE.
- DATE: if `date`≠`days_in_month`, increment and go to IDLE. Otherwise set `date`=01 and go to MONTH.
- MONTH: if `month`≠12, increment and go to IDLE. Otherwise set `month`=01 and go to YEAR.
- YEAR: 99→00 wraps silently, otherwise increment; then go to IDLE.
- BCD increment: low nibble 9 → 0 with a carry into the high nibble; otherwise low nibble +1. Comparisons are on the full 8-bit BCD value.
- `updated` pulses on every transition into IDLE from an update state, and one cycle after a load.
- Tick while busy sets `pending`; only one tick is held. A tick arriving while `pending` is already set, or while busy with `pending` set, sets `overrun`.
- `load` has priority over everything:
  - all fields are written;
  - the state goes to IDLE, or to CLAMP with the macro;
  - `pending` and `overrun` are cleared;
  - a `tick` in the same cycle as `load` is discarded.
- No range checking of `ld_*` values. Out-of-range BCD is carried as-is, and the next rollover compare may never match. This is the caller's responsibility.

## Timing
- Reset values:
  - `year`/`month`/`date` = `RST_*`;
  - `hour`=`min`=`sec`=8'h00;
  - `busy`=0, `updated`=0, `overrun`=0, pending=0, state=IDLE.
- `tick` sampled at edge E0 → `busy`=1 after E0. `sec` changes at E1.
- Number of cycles busy = number of fields touched. Worst case 99-12-31 23:59:59 → 00-01-01 00:00:00 is busy E0..E5; final field written at E6, `busy`=0 and `updated`=1 after E6.
- `days_in_month` must be valid during the DATE state. It uses `year`/`month` as registered before the DATE edge.
- `load` at edge E0: fields visible after E0, `updated`=1 for the following cycle. With the macro, `busy`=1 for one cycle in CLAMP, and `updated` pulses after CLAMP instead.
- Reset asserted mid-ripple returns all outputs to reset values immediately, and any pending tick is lost.

## Configuration
- `BCD_CALENDAR_CLAMP_EN` defined: load enters CLAMP.
  - If `date` > `days_in_month` (BCD compare), `date` := `days_in_month`; this fixes e.g. 02-30 and 02-29 in non-leap years.
  - A tick arriving during CLAMP is held in `pending`.
- Not defined: CLAMP state absent. Load goes directly to IDLE and the date is kept unmodified.

## Test plan
- Reset with defaults → 00-01-01 00:00:00, `busy`=0, `overrun`=0. Then 1 tick → `sec`=01 after two edges, `updated` single pulse.
- Load 24-02-28 23:59:59 (leap, `days_in_month`=29), tick → 24-02-29 00:00:00 after 4 busy cycles. Load 23-02-28 23:59:59 (`days_in_month`=28), tick → 23-03-01 00:00:00.
- Load 99-12-31 23:59:59, tick → 00-01-01 00:00:00, `busy` high exactly 6 cycles.
- Tick, then two further ticks during the same ripple → first held tick processed (`sec` +2 total), `overrun`=1. Subsequent `load` clears `overrun`.
- `load` and `tick` in the same cycle → loaded value unchanged by the tick. `load` during a ripple → ripple aborted, loaded value wins.
- With `BCD_CALENDAR_CLAMP_EN`: load 23-02-30 → `date`=28 after CLAMP. Without the macro: `date`=30 retained.

Source files
------------

// File: rtl/bcd_calendar.sv
// BCD time-of-day / calendar counter with a per-field carry-ripple state machine.
// Optional load-time date clamp enabled by defining BCD_CALENDAR_CLAMP_EN.
module bcd_calendar #(
   parameter logic [7:0] RST_YEAR  = 8'h00,
   parameter logic [7:0] RST_MONTH = 8'h01,
   parameter logic [7:0] RST_DATE  = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] ld_year,
   input  logic [7:0] ld_month,
   input  logic [7:0] ld_date,
   input  logic [7:0] ld_hour,
   input  logic [7:0] ld_min,
   input  logic [7:0] ld_sec,
   input  logic [7:0] days_in_month,
   output logic [7:0] year,
   output logic [7:0] month,
   output logic [7:0] date,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       busy,
   output logic       updated,
   output logic       overrun
);

   typedef enum logic [2:0] {
      StIdle,
      StSec,
      StMin,
      StHour,
      StDate,
      StMonth,
      StYear
`ifdef BCD_CALENDAR_CLAMP_EN
      , StClamp
`endif
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] year_q, year_d, month_q, month_d, date_q, date_d;
   logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic       pending_q, pending_d;
   logic       updated_q, updated_d;
   logic       overrun_q, overrun_d;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] hi;
      hi = v[7:4] + 4'h1;
      if (v[3:0] == 4'h9) return {hi, 4'h0};
      return {v[7:4], v[3:0] + 4'h1};
   endfunction

   always_comb begin
      state_d   = state_q;
      year_d    = year_q;
      month_d   = month_q;
      date_d    = date_q;
      hour_d    = hour_q;
      min_d     = min_q;
      sec_d     = sec_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      updated_d = 1'b0;

      if (load) begin
         year_d    = ld_year;
         month_d   = ld_month;
         date_d    = ld_date;
         hour_d    = ld_hour;
         min_d     = ld_min;
         sec_d     = ld_sec;
         pending_d = 1'b0;
         overrun_d = 1'b0;
`ifdef BCD_CALENDAR_CLAMP_EN
         state_d   = StClamp;
`else
         state_d   = StIdle;
         updated_d = 1'b1;
`endif
      end else begin
         // Only one tick can be held while the ripple is running.
         if (tick && state_q != StIdle) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (tick || pending_q) begin
                  state_d   = StSec;
                  pending_d = 1'b0;
                  if (tick && pending_q) overrun_d = 1'b1;
               end
            end
            StSec: begin
               if (sec_q != 8'h59) begin
                  sec_d     = bcd_inc(sec_q);
                  state_d   = StIdle;
                  updated_d = 1'b1;
               end else begin
                  sec_d   = 8'h00;
                  state_d = StMin;
               end
            end
            StMin: begin
               if (min_q != 8'h59) begin
                  min_d     = bcd_inc(min_q);
                  state_d   = StIdle;
                  updated_d = 1'b1;
               end else begin
                  min_d   = 8'h00;
                  state_d = StHour;
               end
            end
            StHour: begin
               if (hour_q != 8'h23) begin
                  hour_d    = bcd_inc(hour_q);
                  state_d   = StIdle;
                  updated_d = 1'b1;
               end else begin
                  hour_d  = 8'h00;
                  state_d = StDate;
               end
            end
            StDate: begin
               if (date_q != days_in_month) begin
                  date_d    = bcd_inc(date_q);
                  state_d   = StIdle;
                  updated_d = 1'b1;
               end else begin
                  date_d  = 8'h01;
                  state_d = StMonth;
               end
            end
            StMonth: begin
               if (month_q != 8'h12) begin
                  month_d   = bcd_inc(month_q);
                  state_d   = StIdle;
                  updated_d = 1'b1;
               end else begin
                  month_d = 8'h01;
                  state_d = StYear;
               end
            end
            StYear: begin
               year_d    = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
               state_d   = StIdle;
               updated_d = 1'b1;
            end
`ifdef BCD_CALENDAR_CLAMP_EN
            StClamp: begin
               if (date_q > days_in_month) date_d = days_in_month;
               state_d   = StIdle;
               updated_d = 1'b1;
            end
`endif
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         year_q    <= RST_YEAR;
         month_q   <= RST_MONTH;
         date_q    <= RST_DATE;
         hour_q    <= 8'h00;
         min_q     <= 8'h00;
         sec_q     <= 8'h00;
         pending_q <= 1'b0;
         updated_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         year_q    <= year_d;
         month_q   <= month_d;
         date_q    <= date_d;
         hour_q    <= hour_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         pending_q <= pending_d;
         updated_q <= updated_d;
         overrun_q <= overrun_d;
      end
   end

   assign year    = year_q;
   assign month   = month_q;
   assign date    = date_q;
   assign hour    = hour_q;
   assign min     = min_q;
   assign sec     = sec_q;
   assign busy    = (state_q != StIdle);
   assign updated = updated_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_bcd_calendar.sv
// Directed self-checking bench for bcd_calendar; models the date-info stage externally.
module tb_bcd_calendar;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [7:0] ld_year = 8'h00, ld_month = 8'h00, ld_date = 8'h00;
   logic [7:0] ld_hour = 8'h00, ld_min = 8'h00, ld_sec = 8'h00;
   logic [7:0] days_in_month;
   logic [7:0] year, month, date, hour, min, sec;
   logic       busy, updated, overrun;

   int checks = 0;
   int errors = 0;

   bcd_calendar dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .load          (load),
      .ld_year       (ld_year),
      .ld_month      (ld_month),
      .ld_date       (ld_date),
      .ld_hour       (ld_hour),
      .ld_min        (ld_min),
      .ld_sec        (ld_sec),
      .days_in_month (days_in_month),
      .year          (year),
      .month         (month),
      .date          (date),
      .hour          (hour),
      .min           (min),
      .sec           (sec),
      .busy          (busy),
      .updated       (updated),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] dim_model(input logic [7:0] y, input logic [7:0] m);
      int yb;
      yb = int'(y[7:4]) * 10 + int'(y[3:0]);
      case (m)
         8'h02:                      return (yb % 4 == 0) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   always_comb days_in_month = dim_model(year, month);

   logic [47:0] cur;
   assign cur = {year, month, date, hour, min, sec};

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drives a load at a falling edge and waits until any post-load activity has settled.
   task automatic do_load(input logic [47:0] v);
      int n;
      ld_year  = v[47:40];
      ld_month = v[39:32];
      ld_date  = v[31:24];
      ld_hour  = v[23:16];
      ld_min   = v[15:8];
      ld_sec   = v[7:0];
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (busy && n < 5) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL load_settle: busy still %b after %0d cycles", busy, n);
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [47:0] ld;
      logic [47:0] exp;
      int          busy_cyc;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int bc, up;

      vecs[0] = '{48'h24_02_28_23_59_59, 48'h24_02_29_00_00_00, 4};
      vecs[1] = '{48'h23_02_28_23_59_59, 48'h23_03_01_00_00_00, 5};
      vecs[2] = '{48'h99_12_31_23_59_59, 48'h00_01_01_00_00_00, 6};
      vecs[3] = '{48'h23_04_30_12_59_59, 48'h23_04_30_13_00_00, 3};
      vecs[4] = '{48'h23_06_15_09_09_09, 48'h23_06_15_09_09_10, 1};
      vecs[5] = '{48'h23_06_15_09_59_59, 48'h23_06_15_10_00_00, 3};
      vecs[6] = '{48'h23_04_30_23_59_59, 48'h23_05_01_00_00_00, 5};
      vecs[7] = '{48'h23_12_31_23_59_59, 48'h24_01_01_00_00_00, 6};
      vecs[8] = '{48'h19_09_30_23_59_59, 48'h19_10_01_00_00_00, 5};

      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_fields", cur, 48'h00_01_01_00_00_00);
      check("reset_busy", {47'd0, busy}, 48'd0);
      check("reset_updated", {47'd0, updated}, 48'd0);
      check("reset_overrun", {47'd0, overrun}, 48'd0);

      // First tick: busy after E0, sec changes at E1, single updated pulse
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("tick1_busy", {47'd0, busy}, 48'd1);
      check("tick1_sec_e0", {40'd0, sec}, 48'h00);
      @(negedge clk);
      check("tick1_sec_e1", {40'd0, sec}, 48'h01);
      check("tick1_updated", {47'd0, updated}, 48'd1);
      check("tick1_idle", {47'd0, busy}, 48'd0);
      @(negedge clk);
      check("tick1_updated_drop", {47'd0, updated}, 48'd0);

      // Load response: visible after the edge, updated or busy (clamp) next cycle
      ld_year = 8'h23; ld_month = 8'h07; ld_date = 8'h04;
      ld_hour = 8'h11; ld_min = 8'h22; ld_sec = 8'h33;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("load_fields", cur, 48'h23_07_04_11_22_33);
`ifdef BCD_CALENDAR_CLAMP_EN
      check("load_clamp_busy", {47'd0, busy}, 48'd1);
      @(negedge clk);
      check("load_clamp_updated", {47'd0, updated}, 48'd1);
`else
      check("load_updated", {47'd0, updated}, 48'd1);
      check("load_busy", {47'd0, busy}, 48'd0);
`endif
      @(negedge clk);

      // Table of single-tick rollovers
      foreach (vecs[i]) begin
         do_load(vecs[i].ld);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         bc = 0;
         up = 0;
         for (int c = 0; c < 12; c++) begin
            if (busy) bc++;
            if (updated) up++;
            @(negedge clk);
         end
         check($sformatf("vec%0d_fields", i), cur, vecs[i].exp);
         check($sformatf("vec%0d_busy_cycles", i), 48'(bc), 48'(vecs[i].busy_cyc));
         check($sformatf("vec%0d_updated_pulses", i), 48'(up), 48'd1);
      end

      // Two extra ticks during one ripple: one held, one lost
      do_load(48'h23_06_15_10_20_59);
      tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      repeat (6) @(negedge clk);
      check("overrun_fields", cur, 48'h23_06_15_10_21_01);
      check("overrun_flag", {47'd0, overrun}, 48'd1);
      do_load(48'h23_06_15_10_21_01);
      check("overrun_cleared", {47'd0, overrun}, 48'd0);

      // Load and tick in the same cycle: tick discarded
      ld_year = 8'h23; ld_month = 8'h06; ld_date = 8'h15;
      ld_hour = 8'h10; ld_min = 8'h20; ld_sec = 8'h30;
      load = 1'b1;
      tick = 1'b1;
      @(negedge clk);
      load = 1'b0;
      tick = 1'b0;
      repeat (4) @(negedge clk);
      check("load_tick_fields", cur, 48'h23_06_15_10_20_30);
      check("load_tick_idle", {47'd0, busy}, 48'd0);

      // Load during a ripple aborts it
      do_load(48'h99_12_31_23_59_59);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      do_load(48'h23_06_15_10_20_30);
      repeat (8) @(negedge clk);
      check("abort_fields", cur, 48'h23_06_15_10_20_30);
      check("abort_idle", {47'd0, busy}, 48'd0);

      // Out-of-range date on load
      do_load(48'h23_02_30_00_00_00);
`ifdef BCD_CALENDAR_CLAMP_EN
      check("clamp_date", {40'd0, date}, 48'h28);
`else
      check("clamp_date", {40'd0, date}, 48'h30);
`endif

      // Reset mid-ripple: immediate return to defaults, pending tick lost
      do_load(48'h99_12_31_23_59_59);
      tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tick = 1'b0;
      check("rst_mid_fields", cur, 48'h00_01_01_00_00_00);
      check("rst_mid_busy", {47'd0, busy}, 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_after_fields", cur, 48'h00_01_01_00_00_00);
      check("rst_after_busy", {47'd0, busy}, 48'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
